sequence_checker: RTL

- Stores the game's prompt sequence as a list of 3-bit action codes: 1=toggle, 2=push, 3=mic, 4=mouse.
- Scores the player's edge-detected actions against that list one step at a time.
- Sits downstream of the per-input listeners/encoder and upstream of the game controller. The controller receives one-cycle result pulses (match / mismatch / timeout) instead of comparing whole shift-register strings.
- The prompt display reads the same stored list through a read port.

---
 rtl/sequence_checker_pkg.sv | 12 +
 rtl/sequence_checker_store.sv | 33 +++
 rtl/sequence_checker.sv | 110 +++++++++++
 3 files changed

// File: rtl/sequence_checker_pkg.sv
// sequence_checker_pkg: action codes, checker FSM states and code validity helper.
package sequence_checker_pkg;
  localparam logic [2:0] CODE_NONE   = 3'd0;
  localparam logic [2:0] CODE_TOGGLE = 3'd1;
  localparam logic [2:0] CODE_PUSH   = 3'd2;
  localparam logic [2:0] CODE_MIC    = 3'd3;
  localparam logic [2:0] CODE_MOUSE  = 3'd4;
  typedef enum logic [2:0] {IDLE, RUN, PASS, FAIL, TMO} state_e;
  function automatic logic code_is_valid(input logic [2:0] c);
    return c >= CODE_TOGGLE && c <= CODE_MOUSE;
  endfunction
endpackage

// File: rtl/sequence_checker_store.sv
// seq_store: append-only code register file with clear, full flag and two combinational read ports.
module seq_store #(
  parameter int MAX_LEN = 16,
  parameter int IDX_W   = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             wr_i,
  input  logic [2:0]       wr_code_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  input  logic [IDX_W-1:0] chk_idx_i,
  output logic [2:0]       rd_code_o,
  output logic [2:0]       chk_code_o,
  output logic [IDX_W:0]   len_o,
  output logic             full_o
);
  logic [2:0]     mem_q [MAX_LEN];
  logic [IDX_W:0] len_q;
  logic           wr_en;
  assign full_o     = len_q == (IDX_W+1)'(MAX_LEN);
  assign wr_en      = wr_i && !clear_i && !full_o;
  assign len_o      = len_q;
  assign rd_code_o  = mem_q[rd_idx_i];
  assign chk_code_o = mem_q[chk_idx_i];
  always_ff @(posedge clock) begin
    if (reset || clear_i) len_q <= '0;
    else if (wr_en) len_q <= len_q + (IDX_W+1)'(1);
  end
  always_ff @(posedge clock) begin
    if (wr_en) mem_q[len_q[IDX_W-1:0]] <= wr_code_i;
  end
endmodule

// File: rtl/sequence_checker.sv
// sequence_checker: scores player actions against the stored prompt sequence, one code per step.
module sequence_checker
  import sequence_checker_pkg::*;
#(
  parameter int MAX_LEN = 16,
  parameter int IDX_W   = 4,
  parameter int TIMEOUT = 150000000,
  parameter int TO_W    = 28
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             seq_clear,
  input  logic             seq_wr,
  input  logic [2:0]       seq_code,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [2:0]       rd_code,
  output logic [IDX_W:0]   seq_len,
  output logic             full,
  input  logic             start,
  input  logic             act_valid,
  input  logic [2:0]       act_code,
  output logic             busy,
  output logic [IDX_W:0]   step,
  output logic             match,
  output logic             mismatch,
  output logic             timeout
);
  state_e         state_q;
  logic [IDX_W:0] step_q;
  logic [TO_W-1:0] cnt_q;
  logic           busy_q, match_q, mismatch_q, timeout_q;
  logic [2:0]     exp_code;
  logic           act_ok, last_step;
  seq_store #(.MAX_LEN(MAX_LEN), .IDX_W(IDX_W)) u_store (
    .clock     (clock),
    .reset     (reset),
    .clear_i   (seq_clear),
    .wr_i      (seq_wr && state_q == IDLE && code_is_valid(seq_code)),
    .wr_code_i (seq_code),
    .rd_idx_i  (rd_idx),
    .chk_idx_i (step_q[IDX_W-1:0]),
    .rd_code_o (rd_code),
    .chk_code_o(exp_code),
    .len_o     (seq_len),
    .full_o    (full)
  );
  assign act_ok    = act_valid && code_is_valid(act_code);
  assign last_step = step_q == seq_len - (IDX_W+1)'(1);
  assign busy      = busy_q;
  assign step      = step_q;
  assign match     = match_q;
  assign mismatch  = mismatch_q;
  assign timeout   = timeout_q;
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      step_q     <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      match_q    <= 1'b0;
      mismatch_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      match_q    <= 1'b0;
      mismatch_q <= 1'b0;
      timeout_q  <= 1'b0;
      if (seq_clear && state_q == RUN) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
        step_q  <= '0;
      end else begin
        case (state_q)
          IDLE: if (start && !seq_clear) begin
            step_q <= '0;
            if (seq_len != '0) begin
              state_q <= RUN;
              busy_q  <= 1'b1;
              cnt_q   <= TO_W'(TIMEOUT);
            end else begin
              state_q <= PASS;
              match_q <= 1'b1;
            end
          end
          RUN: begin
            // a valid action beats counter expiry in the same cycle
            if (act_ok && act_code == exp_code && last_step) begin
              state_q <= PASS;
              match_q <= 1'b1;
              busy_q  <= 1'b0;
            end else if (act_ok && act_code == exp_code) begin
              step_q <= step_q + (IDX_W+1)'(1);
              cnt_q  <= TO_W'(TIMEOUT);
            end else if (act_ok) begin
              state_q    <= FAIL;
              mismatch_q <= 1'b1;
              busy_q     <= 1'b0;
            end else if (cnt_q == '0) begin
              state_q   <= TMO;
              timeout_q <= 1'b1;
              busy_q    <= 1'b0;
            end else begin
              cnt_q <= cnt_q - TO_W'(1);
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule
